tl_atomic_responder: RTL and testbench
======================================

// Module: tl_atomic_responder
// PURPOSE
//  Slave-side TL-UH atomic executor: accepts ArithmeticData/LogicalData on channel A, does a single-beat
//  read-modify-write on a backing memory port, returns AccessAckData carrying the pre-op value on channel D.
//  Sits in front of the L2/memory SRAM as the far end of L1-issued atomics. One transaction in flight.
// PARAMETERS
//  ADDR_W  32  A-channel / memory address width
//  SRC_W   4   a_source / d_source width
// PORTS
//  clk_i         in   1       clock (single clock domain)
//  rst_ni        in   1       reset, asynchronous, active-low
//  a_valid_i     in   1       A request valid
//  a_ready_o     out  1       A request accepted
//  a_opcode_i    in   3       2=ArithmeticData, 3=LogicalData; others unsupported
//  a_param_i     in   3       Arith: 0 MIN,1 MAX,2 MINU,3 MAXU,4 ADD; Logic: 0 XOR,1 OR,2 AND,3 SWAP
//  a_size_i      in   3       2=word, 3=doubleword
//  a_source_i    in   SRC_W   requester ID, echoed on D
//  a_address_i   in   ADDR_W  byte address
//  a_mask_i      in   8       byte lanes
//  a_data_i      in   64      operand, lane-aligned
//  d_valid_o     out  1       D response valid
//  d_ready_i     in   1       D response accepted
//  d_opcode_o    out  3       always 1 (AccessAckData)
//  d_size_o      out  3       echo of a_size_i
//  d_source_o    out  SRC_W   echo of a_source_i
//  d_denied_o    out  1       request rejected, memory untouched
//  d_data_o      out  64      full 64-bit memory beat before the op; 0 when denied
//  mem_req_o     out  1       memory request, held until mem_gnt_i
//  mem_we_o      out  1       1=write, 0=read
//  mem_addr_o    out  ADDR_W  8-byte aligned address (low 3 bits 0)
//  mem_wmask_o   out  8       write byte enables
//  mem_wdata_o   out  64      write data
//  mem_gnt_i     in   1       request accepted this cycle
//  mem_rvalid_i  in   1       read data valid (>=1 cycle after read grant)
//  mem_rdata_i   in   64      read data
// BEHAVIOUR
//  Reset: state IDLE; a_ready_o=1; d_valid_o, mem_req_o, mem_we_o=0; all other outputs 0.
//  FSM: IDLE -> RD_REQ -> RD_WAIT -> WR_REQ -> RESP -> IDLE; IDLE -> RESP for denied requests.
//  IDLE: a_ready_o=1; on a_valid_i, latch all A fields; legality check, then next state.
//  Legal iff all hold:
//    - opcode in {2,3} and param in its listed range
//    - size=3: addr[2:0]=0 and mask=8'hFF
//    - size=2: addr[1:0]=0 and mask=8'h0F (addr[2]=0) or 8'hF0 (addr[2]=1)
//  Illegal -> RESP with d_denied_o=1, d_data_o=0, no memory traffic.
//  RD_REQ: mem_req_o=1, mem_we_o=0; leave when mem_gnt_i=1. RD_WAIT: capture mem_rdata_i when mem_rvalid_i.
//  Compute on the selected lane only: word = 32-bit lane at [63:32] or [31:0]; dword = 64 bits.
//    MIN/MAX signed, MINU/MAXU unsigned; ADD wraps modulo lane width, no carry out of the lane.
//    No sign extension is written to memory.
//  WR_REQ: mem_req_o=1, mem_we_o=1, mem_wmask_o=latched mask, mem_wdata_o=result in lane (other lanes 0);
//    leave on mem_gnt_i. No write response is awaited.
//  RESP: d_valid_o=1, fields stable until d_ready_i; leave on d_ready_i. a_ready_o=0 outside IDLE.
//  Next A is accepted in the cycle after the D handshake: no back-to-back overlap.
//  Latency with a 0-wait grant and 1-cycle rvalid: A accepted cycle 0 -> d_valid_o in cycle 4.
//  Memory-port stall: mem_req_o and address/data held while mem_gnt_i=0, indefinitely. d_ready_i low stalls RESP.
//  Reset mid-op: aborts immediately, returns to IDLE. A write already granted stands; an ungranted write is dropped.
//  mem_rvalid_i outside RD_WAIT is ignored.
// STRUCTURE
//  tl_atomic_pkg: TL opcode/param localparams (A: ARITH=2, LOGIC=3; D: ACK_DATA=1), size codes, FSM state enum.
//  Sub-module tl_atomic_lane_alu: combinational (opcode, param, size, lane, old, operand) -> lane-aligned new data.
//  Top: FSM, A-field capture registers, memory/D-channel drivers.
// TESTING
//  1. LogicalData SWAP, size 3, addr 0x100, mem=0x1122334455667788, data=0xAAAA..AA
//     -> D data 0x1122334455667788, denied 0; write mask FF, data 0xAAAA..AA.
//  2. ArithmeticData ADD, size 2, addr 0x104, mask F0, mem[63:32]=0xFFFFFFFF, operand 1
//     -> write mask F0, wdata[63:32]=0 (wrap); D data = full old beat.
//  3. MIN vs MINU, size 2, lane 0: old 0x80000000, operand 0x00000001
//     -> MIN writes 0x80000000; MINU writes 0x00000001.
//  4. Illegal: opcode 3 param 5, or size 3 at addr 0x104
//     -> D denied 1, data 0; mem_req_o never asserted.
//  5. Stalls: mem_gnt_i low 3 cycles, then d_ready_i low 2 cycles
//     -> mem outputs and D fields stable throughout; a_ready_o=0 until the D handshake.
//  6. rst_ni asserted in RD_WAIT, then released -> all outputs at reset values; no write issued; next request OK.

Source files
------------

// File: rtl/tl_atomic_pkg.sv
// Shared TL-UH opcode/param codes, size codes, FSM state type and the request legality check
// for the atomic responder.
package tl_atomic_pkg;

  localparam logic [2:0] TlAArith   = 3'd2;
  localparam logic [2:0] TlALogic   = 3'd3;
  localparam logic [2:0] TlDAckData = 3'd1;

  localparam logic [2:0] TlSizeWord  = 3'd2;
  localparam logic [2:0] TlSizeDword = 3'd3;

  localparam logic [2:0] ParamMin  = 3'd0;
  localparam logic [2:0] ParamMax  = 3'd1;
  localparam logic [2:0] ParamMinu = 3'd2;
  localparam logic [2:0] ParamMaxu = 3'd3;
  localparam logic [2:0] ParamAdd  = 3'd4;

  localparam logic [2:0] ParamXor  = 3'd0;
  localparam logic [2:0] ParamOr   = 3'd1;
  localparam logic [2:0] ParamAnd  = 3'd2;
  localparam logic [2:0] ParamSwap = 3'd3;

  typedef enum logic [2:0] {
    StIdle,
    StRdReq,
    StRdWait,
    StWrReq,
    StResp
  } state_e;

  // A word access must be naturally aligned and use exactly the lane its address selects.
  function automatic logic req_legal(input logic [2:0] opcode, input logic [2:0] param,
                                     input logic [2:0] size, input logic [2:0] addr_lo,
                                     input logic [7:0] mask);
    logic op_ok;
    logic shape_ok;
    op_ok = ((opcode == TlAArith) && (param <= ParamAdd)) ||
            ((opcode == TlALogic) && (param <= ParamSwap));
    case (size)
      TlSizeDword: shape_ok = (addr_lo == 3'b000) && (mask == 8'hFF);
      TlSizeWord:  shape_ok = (addr_lo[1:0] == 2'b00) &&
                              (mask == (addr_lo[2] ? 8'hF0 : 8'h0F));
      default:     shape_ok = 1'b0;
    endcase
    return op_ok && shape_ok;
  endfunction

endpackage

// File: rtl/tl_atomic_responder_if.sv
// Channel A / channel D and backing-memory port of the atomic responder, bundled as one interface.
interface tl_atomic_responder_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned SRC_W  = 4
);
  logic              a_valid;
  logic              a_ready;
  logic [2:0]        a_opcode;
  logic [2:0]        a_param;
  logic [2:0]        a_size;
  logic [SRC_W-1:0]  a_source;
  logic [ADDR_W-1:0] a_address;
  logic [7:0]        a_mask;
  logic [63:0]       a_data;

  logic              d_valid;
  logic              d_ready;
  logic [2:0]        d_opcode;
  logic [2:0]        d_size;
  logic [SRC_W-1:0]  d_source;
  logic              d_denied;
  logic [63:0]       d_data;

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wmask;
  logic [63:0]       mem_wdata;
  logic              mem_gnt;
  logic              mem_rvalid;
  logic [63:0]       mem_rdata;

  modport slave (
    input  a_valid, a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data,
    output a_ready,
    output d_valid, d_opcode, d_size, d_source, d_denied, d_data,
    input  d_ready,
    output mem_req, mem_we, mem_addr, mem_wmask, mem_wdata,
    input  mem_gnt, mem_rvalid, mem_rdata
  );

  modport master (
    output a_valid, a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data,
    input  a_ready,
    input  d_valid, d_opcode, d_size, d_source, d_denied, d_data,
    output d_ready,
    input  mem_req, mem_we, mem_addr, mem_wmask, mem_wdata,
    output mem_gnt, mem_rvalid, mem_rdata
  );
endinterface

// File: rtl/tl_atomic_lane_alu.sv
// Combinational atomic ALU: applies the TL arithmetic/logical op to one 32- or 64-bit lane and
// returns the result placed in that lane, all other bits zero.
module tl_atomic_lane_alu
  import tl_atomic_pkg::*;
(
  input  logic [2:0]  opcode_i,
  input  logic [2:0]  param_i,
  input  logic [2:0]  size_i,
  input  logic        lane_i,
  input  logic [63:0] old_i,
  input  logic [63:0] operand_i,
  output logic [63:0] new_o
);

  logic [31:0] old_w, opd_w;
  logic [63:0] a_u, b_u, a_s, b_s, res;
  logic        lt_s, lt_u;

  assign old_w = lane_i ? old_i[63:32] : old_i[31:0];
  assign opd_w = lane_i ? operand_i[63:32] : operand_i[31:0];

  // Word operands are widened so one 64-bit comparator serves both sizes.
  always_comb begin
    if (size_i == TlSizeDword) begin
      a_u = old_i;
      b_u = operand_i;
      a_s = old_i;
      b_s = operand_i;
    end else begin
      a_u = {32'h0, old_w};
      b_u = {32'h0, opd_w};
      a_s = {{32{old_w[31]}}, old_w};
      b_s = {{32{opd_w[31]}}, opd_w};
    end
  end

  assign lt_s = $signed(a_s) < $signed(b_s);
  assign lt_u = a_u < b_u;

  always_comb begin
    res = '0;
    if (opcode_i == TlAArith) begin
      case (param_i)
        ParamMin:  res = lt_s ? a_u : b_u;
        ParamMax:  res = lt_s ? b_u : a_u;
        ParamMinu: res = lt_u ? a_u : b_u;
        ParamMaxu: res = lt_u ? b_u : a_u;
        ParamAdd:  res = a_u + b_u;
        default:   res = '0;
      endcase
    end else begin
      case (param_i)
        ParamXor:  res = a_u ^ b_u;
        ParamOr:   res = a_u | b_u;
        ParamAnd:  res = a_u & b_u;
        ParamSwap: res = b_u;
        default:   res = '0;
      endcase
    end
  end

  // Truncating to the lane drops any word carry and any sign extension.
  always_comb begin
    if (size_i == TlSizeDword) begin
      new_o = res;
    end else if (lane_i) begin
      new_o = {res[31:0], 32'h0};
    end else begin
      new_o = {32'h0, res[31:0]};
    end
  end

endmodule

// File: rtl/tl_atomic_responder.sv
// Slave-side TL-UH atomic executor: one read-modify-write per request on the memory port,
// AccessAckData with the pre-op beat on channel D. One transaction in flight.
module tl_atomic_responder
  import tl_atomic_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned SRC_W  = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  tl_atomic_responder_if.slave  bus
);

  state_e              state_q, state_d;
  logic [2:0]          opcode_q, opcode_d;
  logic [2:0]          param_q, param_d;
  logic [2:0]          size_q, size_d;
  logic [SRC_W-1:0]    source_q, source_d;
  logic [ADDR_W-1:2]   addr_q, addr_d;
  logic [7:0]          mask_q, mask_d;
  logic [63:0]         data_q, data_d;
  logic [63:0]         old_q, old_d;
  logic [63:0]         wdata_q, wdata_d;
  logic                denied_q, denied_d;
  logic [63:0]         alu_new;

  tl_atomic_lane_alu u_alu (
    .opcode_i  (opcode_q),
    .param_i   (param_q),
    .size_i    (size_q),
    .lane_i    (addr_q[2]),
    .old_i     (bus.mem_rdata),
    .operand_i (data_q),
    .new_o     (alu_new)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= StIdle;
      opcode_q <= '0;
      param_q  <= '0;
      size_q   <= '0;
      source_q <= '0;
      addr_q   <= '0;
      mask_q   <= '0;
      data_q   <= '0;
      old_q    <= '0;
      wdata_q  <= '0;
      denied_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      opcode_q <= opcode_d;
      param_q  <= param_d;
      size_q   <= size_d;
      source_q <= source_d;
      addr_q   <= addr_d;
      mask_q   <= mask_d;
      data_q   <= data_d;
      old_q    <= old_d;
      wdata_q  <= wdata_d;
      denied_q <= denied_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    opcode_d = opcode_q;
    param_d  = param_q;
    size_d   = size_q;
    source_d = source_q;
    addr_d   = addr_q;
    mask_d   = mask_q;
    data_d   = data_q;
    old_d    = old_q;
    wdata_d  = wdata_q;
    denied_d = denied_q;
    case (state_q)
      StIdle: begin
        if (bus.a_valid) begin
          opcode_d = bus.a_opcode;
          param_d  = bus.a_param;
          size_d   = bus.a_size;
          source_d = bus.a_source;
          addr_d   = bus.a_address[ADDR_W-1:2];
          mask_d   = bus.a_mask;
          data_d   = bus.a_data;
          old_d    = '0;
          wdata_d  = '0;
          denied_d = !req_legal(bus.a_opcode, bus.a_param, bus.a_size, bus.a_address[2:0],
                                bus.a_mask);
          state_d  = denied_d ? StResp : StRdReq;
        end
      end
      StRdReq: begin
        if (bus.mem_gnt) state_d = StRdWait;
      end
      StRdWait: begin
        if (bus.mem_rvalid) begin
          old_d   = bus.mem_rdata;
          wdata_d = alu_new;
          state_d = StWrReq;
        end
      end
      StWrReq: begin
        if (bus.mem_gnt) state_d = StResp;
      end
      StResp: begin
        if (bus.d_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // D fields are forced to zero outside RESP so idle outputs match the reset values.
  always_comb begin
    bus.a_ready   = (state_q == StIdle);
    bus.d_valid   = (state_q == StResp);
    bus.d_opcode  = bus.d_valid ? TlDAckData : 3'd0;
    bus.d_size    = bus.d_valid ? size_q : 3'd0;
    bus.d_source  = bus.d_valid ? source_q : '0;
    bus.d_denied  = bus.d_valid & denied_q;
    bus.d_data    = bus.d_valid ? old_q : 64'h0;
    bus.mem_req   = (state_q == StRdReq) || (state_q == StWrReq);
    bus.mem_we    = (state_q == StWrReq);
    bus.mem_addr  = {addr_q[ADDR_W-1:3], 3'b000};
    bus.mem_wmask = bus.mem_we ? mask_q : 8'h00;
    bus.mem_wdata = bus.mem_we ? wdata_q : 64'h0;
  end

endmodule

// File: tb/tb_tl_atomic_responder.sv
// Scoreboard bench for tl_atomic_responder: a behavioural memory, a D-channel monitor and
// expected D beats / memory writes queued at request time.
module tb_tl_atomic_responder;
  import tl_atomic_pkg::*;

  typedef struct {
    logic        denied;
    logic [63:0] data;
    logic [3:0]  source;
    logic [2:0]  size;
  } d_exp_t;

  typedef struct {
    logic [31:0] addr;
    logic [7:0]  mask;
    logic [63:0] data;
  } w_exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  tl_atomic_responder_if #(.ADDR_W(32), .SRC_W(4)) bus ();

  tl_atomic_responder #(.ADDR_W(32), .SRC_W(4)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  d_exp_t      d_q[$];
  w_exp_t      w_q[$];
  logic [63:0] mem [bit [31:0]];
  int          n_cmp = 0;
  int          n_err = 0;
  int unsigned cyc = 0;
  int unsigned acc_cyc = 0;
  bit          chk_lat = 1'b0;
  int          gnt_stall = 0;
  int          d_stall = 0;
  int          req_cycles = 0;
  int          writes_seen = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] mem_rd(input logic [31:0] a);
    bit [31:0] k;
    k = a;
    return mem.exists(k) ? mem[k] : 64'h0;
  endfunction

  function automatic bit tb_legal(input logic [2:0] op, input logic [2:0] prm,
                                  input logic [2:0] sz, input logic [31:0] addr,
                                  input logic [7:0] mask);
    bit ok_op, ok_shape;
    ok_op = (op == 3'd2 && prm < 3'd5) || (op == 3'd3 && prm < 3'd4);
    if (sz == 3'd3)      ok_shape = (addr[2:0] == 3'd0) && (mask == 8'hFF);
    else if (sz == 3'd2) ok_shape = (addr[1:0] == 2'd0) && (mask == (addr[2] ? 8'hF0 : 8'h0F));
    else                 ok_shape = 1'b0;
    return ok_op && ok_shape;
  endfunction

  function automatic logic [63:0] tb_new(input logic [2:0] op, input logic [2:0] prm,
                                         input logic [2:0] sz, input logic hi,
                                         input logic [63:0] old, input logic [63:0] opd);
    logic [31:0] x, y, z;
    logic [63:0] r;
    r = 64'h0;
    if (sz == 3'd3) begin
      case ({op, prm})
        6'o20: r = ($signed(old) < $signed(opd)) ? old : opd;
        6'o21: r = ($signed(old) > $signed(opd)) ? old : opd;
        6'o22: r = (old < opd) ? old : opd;
        6'o23: r = (old > opd) ? old : opd;
        6'o24: r = old + opd;
        6'o30: r = old ^ opd;
        6'o31: r = old | opd;
        6'o32: r = old & opd;
        default: r = opd;
      endcase
    end else begin
      x = hi ? old[63:32] : old[31:0];
      y = hi ? opd[63:32] : opd[31:0];
      case ({op, prm})
        6'o20: z = ($signed(x) < $signed(y)) ? x : y;
        6'o21: z = ($signed(x) > $signed(y)) ? x : y;
        6'o22: z = (x < y) ? x : y;
        6'o23: z = (x > y) ? x : y;
        6'o24: z = x + y;
        6'o30: z = x ^ y;
        6'o31: z = x | y;
        6'o32: z = x & y;
        default: z = y;
      endcase
      r = hi ? {z, 32'h0} : {32'h0, z};
    end
    return r;
  endfunction

  task automatic send(input logic [2:0] op, input logic [2:0] prm, input logic [2:0] sz,
                      input logic [3:0] src, input logic [31:0] addr, input logic [7:0] mask,
                      input logic [63:0] data);
    d_exp_t de;
    w_exp_t we;
    logic [31:0] al;
    bit ok, acc;
    al = {addr[31:3], 3'b000};
    ok = tb_legal(op, prm, sz, addr, mask);
    de.denied = !ok;
    de.data   = ok ? mem_rd(al) : 64'h0;
    de.source = src;
    de.size   = sz;
    d_q.push_back(de);
    if (ok) begin
      we.addr = al;
      we.mask = mask;
      we.data = tb_new(op, prm, sz, addr[2], mem_rd(al), data);
      w_q.push_back(we);
    end
    @(negedge clk);
    bus.a_valid = 1'b1; bus.a_opcode = op; bus.a_param = prm; bus.a_size = sz;
    bus.a_source = src; bus.a_address = addr; bus.a_mask = mask; bus.a_data = data;
    acc = 1'b0;
    for (int i = 0; i < 100 && !acc; i++) begin
      if (bus.a_ready) begin
        acc = 1'b1;
        acc_cyc = cyc;
      end else begin
        @(negedge clk);
      end
    end
    if (!acc) check_eq("a_accept_timeout", acc, 1);
    @(negedge clk);
    bus.a_valid = 1'b0;
  endtask

  task automatic wait_done();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 300 && !done; i++) begin
      @(negedge clk);
      done = (d_q.size() == 0) && (w_q.size() == 0) && (bus.a_ready == 1'b1);
    end
    if (!done) check_eq("txn_timeout", done, 1);
  endtask

  // Memory model: grants after gnt_stall idle cycles, read data one cycle after the grant.
  initial begin
    bit          rd_pend, stalled;
    logic [31:0] rd_addr, s_addr;
    logic        s_we;
    logic [7:0]  s_mask;
    logic [63:0] s_wdata, cur;
    w_exp_t      w;
    rd_pend = 0; stalled = 0; rd_addr = '0;
    s_addr = '0; s_we = 0; s_mask = '0; s_wdata = '0;
    bus.mem_gnt = 0; bus.mem_rvalid = 0; bus.mem_rdata = '0;
    forever begin
      @(negedge clk);
      bus.mem_gnt = 1'b0;
      bus.mem_rvalid = 1'b0;
      if (!rst_n) begin
        rd_pend = 0;
        stalled = 0;
      end else begin
        if (rd_pend) begin
          bus.mem_rvalid = 1'b1;
          bus.mem_rdata = mem_rd(rd_addr);
          rd_pend = 0;
        end
        if (bus.mem_req) begin
          req_cycles++;
          if (stalled) begin
            check_eq("stall_addr", bus.mem_addr, s_addr);
            check_eq("stall_we", bus.mem_we, s_we);
            check_eq("stall_wmask", bus.mem_wmask, s_mask);
            check_eq("stall_wdata", bus.mem_wdata, s_wdata);
            check_eq("stall_a_ready", bus.a_ready, 0);
          end
          if (gnt_stall > 0) begin
            gnt_stall--;
            stalled = 1;
            s_addr = bus.mem_addr; s_we = bus.mem_we;
            s_mask = bus.mem_wmask; s_wdata = bus.mem_wdata;
          end else begin
            stalled = 0;
            bus.mem_gnt = 1'b1;
            check_eq("mem_op_expected", w_q.size() != 0, 1);
            if (w_q.size() != 0) begin
              if (!bus.mem_we) begin
                rd_pend = 1;
                rd_addr = bus.mem_addr;
                check_eq("rd_addr", bus.mem_addr, w_q[0].addr);
              end else begin
                w = w_q.pop_front();
                writes_seen++;
                check_eq("wr_addr", bus.mem_addr, w.addr);
                check_eq("wr_mask", bus.mem_wmask, w.mask);
                check_eq("wr_data", bus.mem_wdata, w.data);
                cur = mem_rd(w.addr);
                for (int b = 0; b < 8; b++)
                  if (w.mask[b]) cur[b*8 +: 8] = w.data[b*8 +: 8];
                mem[w.addr] = cur;
              end
            end
          end
        end else begin
          stalled = 0;
        end
      end
    end
  end

  // D-channel monitor: holds d_ready low for d_stall cycles, checks hold stability and content.
  initial begin
    bit          seen;
    logic [63:0] h_data;
    logic        h_den;
    logic [3:0]  h_src;
    logic [2:0]  h_size;
    d_exp_t      e;
    seen = 0; h_data = '0; h_den = 0; h_src = '0; h_size = '0;
    bus.d_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n && bus.d_valid) begin
        if (!seen) begin
          seen = 1;
          if (chk_lat) check_eq("latency", cyc - acc_cyc, 4);
        end else begin
          check_eq("d_hold_data", bus.d_data, h_data);
          check_eq("d_hold_denied", bus.d_denied, h_den);
          check_eq("d_hold_source", bus.d_source, h_src);
          check_eq("d_hold_size", bus.d_size, h_size);
          check_eq("resp_a_ready", bus.a_ready, 0);
        end
        h_data = bus.d_data; h_den = bus.d_denied; h_src = bus.d_source; h_size = bus.d_size;
        if (d_stall > 0) begin
          d_stall--;
          bus.d_ready = 1'b0;
        end else begin
          bus.d_ready = 1'b1;
          seen = 0;
          check_eq("d_expected", d_q.size() != 0, 1);
          if (d_q.size() != 0) begin
            e = d_q.pop_front();
            check_eq("d_opcode", bus.d_opcode, TlDAckData);
            check_eq("d_denied", bus.d_denied, e.denied);
            check_eq("d_data", bus.d_data, e.data);
            check_eq("d_source", bus.d_source, e.source);
            check_eq("d_size", bus.d_size, e.size);
          end
        end
      end else begin
        bus.d_ready = 1'b0;
        seen = 0;
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_a_ready"}, bus.a_ready, 1);
    check_eq({tag, "_d_valid"}, bus.d_valid, 0);
    check_eq({tag, "_mem_req"}, bus.mem_req, 0);
    check_eq({tag, "_mem_we"}, bus.mem_we, 0);
    check_eq({tag, "_d_data"}, bus.d_data, 0);
    check_eq({tag, "_mem_wmask"}, bus.mem_wmask, 0);
  endtask

  initial begin
    int rc, ws;
    bus.a_valid = 0; bus.a_opcode = '0; bus.a_param = '0; bus.a_size = '0;
    bus.a_source = '0; bus.a_address = '0; bus.a_mask = '0; bus.a_data = '0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;

    // SWAP dword, also the zero-wait latency check
    mem[32'h100] = 64'h1122334455667788;
    chk_lat = 1'b1;
    send(3'd3, 3'd3, 3'd3, 4'd5, 32'h100, 8'hFF, 64'hAAAAAAAAAAAAAAAA);
    wait_done();
    chk_lat = 1'b0;

    // ADD word in the upper lane wraps to zero
    mem[32'h100] = 64'hFFFFFFFF_0BADF00D;
    send(3'd2, 3'd4, 3'd2, 4'd9, 32'h104, 8'hF0, 64'h00000001_00000000);
    wait_done();

    // MIN then MINU on lane 0 with 0x80000000 vs 1
    mem[32'h200] = 64'h12345678_80000000;
    send(3'd2, 3'd0, 3'd2, 4'd1, 32'h200, 8'h0F, 64'h1);
    wait_done();
    send(3'd2, 3'd2, 3'd2, 4'd2, 32'h200, 8'h0F, 64'h1);
    wait_done();

    // A few more ops across both sizes and lanes
    mem[32'h300] = 64'hFFFFFFFF_FFFFFFFE;
    send(3'd2, 3'd1, 3'd3, 4'd3, 32'h300, 8'hFF, 64'h5);
    wait_done();
    mem[32'h308] = 64'hFFFFFFFF_FFFFFFFF;
    send(3'd2, 3'd4, 3'd3, 4'd4, 32'h308, 8'hFF, 64'h2);
    wait_done();
    mem[32'h310] = 64'hF0F0F0F0_0000FFFF;
    send(3'd3, 3'd0, 3'd2, 4'd6, 32'h314, 8'hF0, 64'hFF00FF00_00000000);
    wait_done();
    send(3'd3, 3'd2, 3'd2, 4'd7, 32'h310, 8'h0F, 64'h0000FF0F);
    wait_done();
    mem[32'h318] = 64'h7FFFFFFF_00000000;
    send(3'd2, 3'd3, 3'd2, 4'd8, 32'h31C, 8'hF0, 64'h80000000_12345678);
    wait_done();

    // Illegal requests produce denied responses and no memory traffic
    rc = req_cycles;
    send(3'd3, 3'd5, 3'd3, 4'd10, 32'h100, 8'hFF, 64'h1);
    wait_done();
    send(3'd2, 3'd4, 3'd3, 4'd11, 32'h104, 8'hFF, 64'h1);
    wait_done();
    send(3'd2, 3'd4, 3'd2, 4'd12, 32'h104, 8'h0F, 64'h1);
    wait_done();
    send(3'd0, 3'd0, 3'd3, 4'd13, 32'h100, 8'hFF, 64'h1);
    wait_done();
    check_eq("illegal_mem_req_cycles", req_cycles, rc);

    // Grant and D-ready stalls
    mem[32'h400] = 64'h0123456789ABCDEF;
    gnt_stall = 3;
    d_stall = 2;
    send(3'd3, 3'd1, 3'd3, 4'd14, 32'h400, 8'hFF, 64'hF000000000000000);
    wait_done();

    // Reset while waiting for read data
    mem[32'h500] = 64'h5555555555555555;
    ws = writes_seen;
    send(3'd3, 3'd3, 3'd3, 4'd15, 32'h500, 8'hFF, 64'h0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midop_reset");
    d_q.delete();
    w_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check_eq("midop_no_write", writes_seen, ws);
    check_eq("midop_idle_a_ready", bus.a_ready, 1);
    send(3'd2, 3'd4, 3'd3, 4'd3, 32'h500, 8'hFF, 64'h1);
    wait_done();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
